// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter (dmem_arbiter) and its counters.
package dmem_arb_pkg;

    localparam int DEF_AW       = 10;
    localparam int DEF_DW       = 32;
    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_LOCK_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_DMA  = 2'd2,
        ST_LOCK = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // Bits needed to hold 0..max inclusive.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-high reset.
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != WIDTH'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: reset is only looked at on the clock edge, so it sits inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core priority, DMA starvation guard, DMA burst lock.
// Optional build macro DMEM_ARB_PERF_EN adds core-stall and DMA-grant cycle counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]   core_stall_cnt,
    output logic [31:0]   dma_grant_cnt,
`endif
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WAIT_W = cnt_width(MAX_WAIT);
    localparam int LOCK_W = cnt_width(LOCK_MAX);

    // rst_n keeps its historical name but is active-high and synchronous.
    arb_state_e        state_q;
    arb_state_e        state_d;
    owner_e            owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              wait_full;
    logic              lock_full;
    logic              wait_inc;
    logic              lock_inc;
    logic              lock_clr;

    assign wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign lock_full = (lock_cnt == LOCK_W'(LOCK_MAX));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (owner)
            OWN_CORE: state_d = ST_CORE;
            OWN_DMA:  state_d = dma_lock ? ST_LOCK : ST_DMA;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Grant is decided combinationally so the memory access happens in the request cycle.
    // NOTE: every comb output gets a default first, otherwise unassigned paths infer latches.
    always_comb begin
        owner      = OWN_NONE;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        core_rdata = '0;
        dma_rdata  = '0;
        dma_gnt    = 1'b0;

        if (!rst_n) begin
            if ((state_q == ST_LOCK) && dma_req && !(lock_full && core_req)) begin
                owner = OWN_DMA;
            end else if (dma_req && wait_full) begin
                owner = OWN_DMA;
            end else if (core_req) begin
                owner = OWN_CORE;
            end else if (dma_req) begin
                owner = OWN_DMA;
            end
        end

        case (owner)
            OWN_CORE: begin
                mem_addr   = core_addr;
                mem_we     = core_we;
                mem_wdata  = core_wdata;
                core_rdata = mem_rdata;
            end
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_we    = dma_we;
                mem_wdata = dma_wdata;
                dma_rdata = mem_rdata;
                dma_gnt   = 1'b1;
            end
            default: ;
        endcase
    end

    assign core_stall = core_req && !rst_n && (owner != OWN_CORE);

    assign wait_inc = dma_req && !dma_gnt;
    assign lock_inc = dma_gnt && dma_lock;
    assign lock_clr = (state_d != ST_LOCK);

    sat_counter #(
        .WIDTH (WAIT_W),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_i (rst_n),
        .inc_i (wait_inc),
        .clr_i (!wait_inc),
        .cnt_o (wait_cnt)
    );

    sat_counter #(
        .WIDTH (LOCK_W),
        .MAX   (LOCK_MAX)
    ) u_lock_cnt (
        .clk   (clk),
        .rst_i (rst_n),
        .inc_i (lock_inc),
        .clr_i (lock_clr),
        .cnt_o (lock_cnt)
    );

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] gnt_cnt_q;

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_cnt_q <= '0;
            gnt_cnt_q   <= '0;
        end else begin
            if (core_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (dma_gnt)    gnt_cnt_q   <= gnt_cnt_q + 32'd1;
        end
    end

    assign core_stall_cnt = stall_cnt_q;
    assign dma_grant_cnt  = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_dmem_arbiter;

    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;
    localparam int LOCK_MAX = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_stall;
    logic          dma_req, dma_we, dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          dma_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   core_stall_cnt, dma_grant_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_lock   (dma_lock),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
`ifdef DMEM_ARB_PERF_EN
        .core_stall_cnt (core_stall_cnt),
        .dma_grant_cnt  (dma_grant_cnt),
`endif
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Datafile stand-in: combinational read, write on the rising edge.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model, expressed in the arbitration rules' own terms.
    bit m_burst = 1'b0;   // DMA holds a lock into the next cycle
    int m_wait  = 0;      // cycles DMA has waited
    int m_run   = 0;      // consecutive locked DMA grants
    int m_own   = 0;      // 0 none, 1 core, 2 dma

    logic          o_dma_gnt, o_core_stall, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_core_rdata, o_dma_rdata;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    // One clock cycle: predict, compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle(input string tag);
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wdata, e_crd, e_drd;
        @(negedge clk);
        if (rst_n)                                                  m_own = 0;
        else if (m_burst && dma_req && !(m_run == LOCK_MAX && core_req)) m_own = 2;
        else if (dma_req && m_wait == MAX_WAIT)                     m_own = 2;
        else if (core_req)                                          m_own = 1;
        else if (dma_req)                                           m_own = 2;
        else                                                        m_own = 0;

        e_addr  = (m_own == 1) ? core_addr  : (m_own == 2) ? dma_addr  : '0;
        e_we    = (m_own == 1) ? core_we    : (m_own == 2) ? dma_we    : 1'b0;
        e_wdata = (m_own == 1) ? core_wdata : (m_own == 2) ? dma_wdata : '0;
        e_crd   = (m_own == 1) ? ram[e_addr] : '0;
        e_drd   = (m_own == 2) ? ram[e_addr] : '0;

        check({tag, ".dma_gnt"},    DW'(dma_gnt),    DW'(m_own == 2));
        check({tag, ".core_stall"}, DW'(core_stall), DW'(core_req && !rst_n && m_own != 1));
        check({tag, ".mem_we"},     DW'(mem_we),     DW'(e_we));
        check({tag, ".mem_addr"},   DW'(mem_addr),   DW'(e_addr));
        check({tag, ".mem_wdata"},  mem_wdata,       e_wdata);
        check({tag, ".core_rdata"}, core_rdata,      e_crd);
        check({tag, ".dma_rdata"},  dma_rdata,       e_drd);

        o_dma_gnt = dma_gnt; o_core_stall = core_stall; o_mem_we = mem_we;
        o_mem_addr = mem_addr; o_core_rdata = core_rdata; o_dma_rdata = dma_rdata;

        if (rst_n) begin
            m_burst = 1'b0; m_wait = 0; m_run = 0;
        end else begin
            if (m_own == 2 && dma_lock) begin
                m_burst = 1'b1;
                if (m_run < LOCK_MAX) m_run++;
            end else begin
                m_burst = 1'b0;
                m_run   = 0;
            end
            if (dma_req && m_own != 2) begin
                if (m_wait < MAX_WAIT) m_wait++;
            end else begin
                m_wait = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  core_grants;
        int  n_dma;
        bit  done;
`ifdef DMEM_ARB_PERF_EN
        logic [31:0] stall_snap, gnt_snap;
`endif

        // Reset held with live requests: nothing may reach the memory.
        idle_inputs();
        rst_n = 1'b1;
        core_req = 1'b1; core_we = 1'b1; dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1;
        cycle("reset0");
        cycle("reset1");
        check("reset.mem_we", DW'(o_mem_we), '0);
        rst_n = 1'b0;
        idle_inputs();
        cycle("idle0");

        // Core write then readback.
        core_req = 1'b1; core_we = 1'b1; core_addr = 10'h010; core_wdata = 32'hDEADBEEF;
        cycle("t1_wr");
        check("t1.mem_we", DW'(o_mem_we), 32'd1);
        check("t1.stall",  DW'(o_core_stall), '0);
        core_we = 1'b0; core_wdata = '0;
        cycle("t1_rd");
        check("t1.readback", o_core_rdata, 32'hDEADBEEF);
        idle_inputs();
        cycle("t1_idle");

        // Both requesting: core wins until DMA has waited MAX_WAIT cycles.
        core_req = 1'b1; core_addr = 10'h020;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h030; dma_wdata = 32'h12345678;
        core_grants = 0; done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            cycle("t2");
            if (o_dma_gnt) done = 1'b1;
            else if (!o_core_stall) core_grants++;
        end
        check("t2.bound",       DW'(done), 32'd1);
        check("t2.core_grants", DW'(core_grants), 32'd4);
        check("t2.stall_on_dma", DW'(o_core_stall), 32'd1);
        idle_inputs();
        cycle("t2_idle");

        // Lock burst with the core waiting: LOCK_MAX grants, one core grant, then DMA relocks.
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1; dma_addr = 10'h080; dma_wdata = 32'hA5A50000;
        n_dma = 0; done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("t3_pre");
            if (o_dma_gnt) n_dma++;
            dma_addr = dma_addr + 1'b1; dma_wdata = dma_wdata + 1;
        end
        core_req = 1'b1; core_addr = 10'h040;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle("t3");
            if (o_dma_gnt) n_dma++;
            else done = 1'b1;
            dma_addr = dma_addr + 1'b1; dma_wdata = dma_wdata + 1;
        end
        check("t3.bound",         DW'(done), 32'd1);
        check("t3.locked_grants", DW'(n_dma), DW'(LOCK_MAX));
        check("t3.core_granted",  DW'(o_core_stall), '0);
        core_req = 1'b0;
        cycle("t3_relock");
        check("t3.relock", DW'(o_dma_gnt), 32'd1);
        idle_inputs();
        cycle("t3_idle");

        // Lock dropped on word 3: word 3 still granted, core takes the next cycle.
        dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 10'h100; dma_wdata = 32'h0000_0001;
        cycle("t4_w1");
        core_req = 1'b1; core_addr = 10'h010;
        dma_addr = 10'h101; dma_wdata = 32'h0000_0002;
        cycle("t4_w2");
        check("t4.w2_gnt", DW'(o_dma_gnt), 32'd1);
        dma_lock = 1'b0; dma_addr = 10'h102; dma_wdata = 32'h0000_0003;
        cycle("t4_w3");
        check("t4.w3_gnt", DW'(o_dma_gnt), 32'd1);
        dma_addr = 10'h103;
        cycle("t4_core");
        check("t4.core_gnt", DW'(o_core_stall), '0);
        check("t4.dma_wait", DW'(o_dma_gnt), '0);
        core_req = 1'b0;
        cycle("t4_dma");
        idle_inputs();
        cycle("t4_idle");

        // Reset in the middle of a write burst.
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1; dma_addr = 10'h200; dma_wdata = 32'hCAFE0000;
        cycle("t5_b0");
        dma_addr = 10'h201; dma_wdata = 32'hCAFE0001;
        cycle("t5_b1");
        rst_n = 1'b1; core_req = 1'b1; dma_addr = 10'h202; dma_wdata = 32'hCAFE0002;
        cycle("t5_rst");
        check("t5.mem_we",  DW'(o_mem_we), '0);
        check("t5.dma_gnt", DW'(o_dma_gnt), '0);
        check("t5.stall",   DW'(o_core_stall), '0);
        rst_n = 1'b0;
        cycle("t5_post");
        check("t5.lock_dropped", DW'(o_dma_gnt), '0);
        idle_inputs();
        cycle("t5_idle");

        // No requests.
`ifdef DMEM_ARB_PERF_EN
        stall_snap = core_stall_cnt; gnt_snap = dma_grant_cnt;
`endif
        cycle("t6");
        check("t6.mem_we",     DW'(o_mem_we), '0);
        check("t6.mem_addr",   DW'(o_mem_addr), '0);
        check("t6.core_rdata", o_core_rdata, '0);
        check("t6.dma_rdata",  o_dma_rdata, '0);
`ifdef DMEM_ARB_PERF_EN
        cycle("t6b");
        check("t6.stall_cnt", core_stall_cnt, stall_snap);
        check("t6.gnt_cnt",   dma_grant_cnt, gnt_snap);
`endif

        // Randomized traffic; a requester keeps its request stable until granted.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(99) == 0);
            if (!(core_req && m_own != 1)) begin
                core_req   = ($urandom_range(2) != 0);
                core_we    = $urandom_range(1);
                core_addr  = AW'($urandom_range(15));
                core_wdata = $urandom;
            end
            if (!(dma_req && m_own != 2)) begin
                dma_req   = $urandom_range(1);
                dma_lock  = ($urandom_range(3) != 0);
                dma_we    = $urandom_range(1);
                dma_addr  = AW'($urandom_range(15));
                dma_wdata = $urandom;
            end
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
